inst_prefetch_q: RTL

INST_PREFETCH_Q -- requirements
Module: inst_prefetch_q

---
 rtl/inst_prefetch_q_pkg.sv | 21 ++
 rtl/inst_pq_fifo.sv | 57 +++++
 rtl/inst_prefetch_q.sv | 75 +++++++
 3 files changed

// File: rtl/inst_prefetch_q_pkg.sv
// Shared widths, PC step and queue entry layout
// for the instruction prefetch queue.
package inst_prefetch_q_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   localparam logic [INST_ADDR_W-1:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [INST_ADDR_W-1:0] pc;
      logic [INST_W-1:0]      inst;
   } pq_entry_t;

   function automatic logic [INST_ADDR_W-1:0] pc_align(
      input logic [INST_ADDR_W-1:0] pc
   );
      return {pc[INST_ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_pq_fifo.sv
// Circular entry store with read/write pointers
// and occupancy count; storage is left unreset.
module inst_pq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [W-1:0]           i_wdata,
   output logic [W-1:0]           o_rdata,
   output logic [$clog2(DEPTH):0] o_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_cnt;

   // entry write; flush suppresses the push
   always_ff @(posedge clk) begin
      if (i_push && !i_flush)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (i_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (i_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         unique case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_rdata = (r_cnt != '0) ? r_mem[r_rd_ptr] : '0;
   assign o_cnt   = r_cnt;

endmodule

// File: rtl/inst_prefetch_q.sv
// Sequential instruction prefetcher feeding decode
// from a combinational ROM, flushed on redirect.
module inst_prefetch_q
   import inst_prefetch_q_pkg::*;
#(
   parameter int                     DEPTH    = 4,
   parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   rom_ce_o,
   output logic [INST_ADDR_W-1:0] rom_addr_o,
   input  logic [INST_W-1:0]      rom_data_i,
   output logic                   id_valid_o,
   output logic [INST_ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0]      id_inst_o,
   input  logic                   id_ready_i,
   input  logic                   redirect_i,
   input  logic [INST_ADDR_W-1:0] redirect_pc_i,
   output logic [$clog2(DEPTH):0] q_cnt_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic                   r_fetch_en;
   logic [INST_ADDR_W-1:0] r_fetch_pc;
   logic                   w_push;
   logic                   w_pop;
   logic [CW-1:0]          w_cnt;
   pq_entry_t              w_head;
   pq_entry_t              w_wr;

   assign w_pop  = id_valid_o & id_ready_i & ~redirect_i;
   assign w_push = r_fetch_en & ~redirect_i
                 & ((w_cnt < FULL) | w_pop);

   assign w_wr = '{pc: r_fetch_pc, inst: rom_data_i};

   inst_pq_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(pq_entry_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (redirect_i),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wr),
      .o_rdata (w_head),
      .o_cnt   (w_cnt)
   );

   // fetch enable arms one edge after reset; PC steps or redirects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_en <= 1'b0;
         r_fetch_pc <= RESET_PC;
      end else begin
         r_fetch_en <= 1'b1;
         if (redirect_i)
            r_fetch_pc <= pc_align(redirect_pc_i);
         else if (w_push)
            r_fetch_pc <= r_fetch_pc + PC_INC;
      end
   end

   assign rom_ce_o   = w_push;
   assign rom_addr_o = r_fetch_pc;
   assign id_valid_o = (w_cnt != '0);
   assign id_pc_o    = w_head.pc;
   assign id_inst_o  = w_head.inst;
   assign q_cnt_o    = w_cnt;

endmodule
